max_pool_2x2: RTL and testbench
===============================

// Module: max_pool_2x2
// PURPOSE
//  2x2, stride-2 max-pooling stage of the YOLO CNN datapath, placed after a convolution layer.
//  Takes one square feature map of ARRAY_WIDTH x ARRAY_WIDTH unsigned values, row-major.
//  For each non-overlapping 2x2 window it emits the maximum value.
//  Output is a registered RESULT_WIDTH x RESULT_WIDTH map, with a valid flag.
// PARAMETERS (from yolo_params_pkg)
//  IP_DATA_WIDTH  7  MSB index of each element; element width = IP_DATA_WIDTH+1 bits (8).
//  ARRAY_WIDTH    4  input map side length; must be >= 2.
//  RESULT_WIDTH   2  output map side length; must equal ARRAY_WIDTH/2.
// PORTS
//  clk        in   1    single clock; all state updates on the rising edge.
//  rst_n      in   1    synchronous, active-low reset.
//  in_valid   in   1    input_vec holds a complete map to pool this cycle.
//  input_vec  in   [IP_DATA_WIDTH:0] x ARRAY_WIDTH**2    unpacked [0:AW*AW-1]; element (r,c) at index r*AW+c.
//  out_valid  out  1    result holds a freshly pooled map.
//  result     out  [IP_DATA_WIDTH:0] x RESULT_WIDTH**2   unpacked [0:RW*RW-1]; element (i,j) at index i*RW+j.
// BEHAVIOUR
//  - Reset: on a rising edge with rst_n=0, every result element is 0 and out_valid is 0.
//    Reset overrides in_valid.
//  - Pooling function:
//    result[i*RW+j] = max of input (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1).
//  - Compare is unsigned over the full IP_DATA_WIDTH+1 bits. No truncation or saturation.
//    Output width equals input width.
//  - Ties: equal maxima yield that value; no tie-break state is needed.
//  - Latency: 1 cycle. If in_valid=1 at edge N (rst_n=1), then after edge N result holds that
//    map's maxima and out_valid=1.
//  - Throughput: one map per cycle. Back-to-back in_valid gives back-to-back out_valid.
//    No stall or backpressure.
//  - in_valid=0 at an edge: out_valid goes to 0; result holds its last value (no update).
//  - The max tree is purely combinational: three 2-input compares per window, balanced two levels.
//    Only the output registers are clocked.
//  - Odd ARRAY_WIDTH: the last row and last column are ignored (floor division).
//  - Elaboration check: $error if RESULT_WIDTH != ARRAY_WIDTH/2 or ARRAY_WIDTH < 2.
//  - Reset mid-stream: any pending result is discarded. The first valid input after rst_n rises
//    produces output one cycle later, as normal.
//  - X on input_vec while in_valid=0 must not propagate to result.
// TESTING
//  1. Reset: hold rst_n=0 for 2 edges with random input and in_valid=1 -> result all 0, out_valid=0.
//  2. Ramp: input_vec[i]=i (0..15), in_valid=1 for one cycle
//     -> next cycle result={5,7,13,15}, out_valid=1; then out_valid=0 and result holds.
//  3. Position sweep: window holds a single 8'hFF at each of its 4 positions in turn, others 0
//     -> the matching result element = 255 and the rest = 0.
//  4. Extremes/ties: all elements 8'hFF -> all results 255. Window {3,3,3,3} -> 3.
//     Window {128,127,0,1} -> 128 (unsigned compare).
//  5. Streaming: 3 random maps on consecutive cycles -> 3 consecutive out_valid.
//     Each result matches the reference model one cycle after its input.
//  6. Reset mid-stream: rst_n=0 during the cycle after a valid map -> outputs are 0/0,
//     and the map is not emitted.

Source files
------------

// File: rtl/max_pool_2x2.sv
// -----------------------------------------------------------------------------
// max_pool_2x2
//   2x2, stride-2 max-pooling stage of the YOLO CNN datapath. A complete
//   ARRAY_WIDTH x ARRAY_WIDTH feature map (row-major, unsigned elements) is
//   presented in one cycle. Each non-overlapping 2x2 window is reduced to its
//   maximum, and the RESULT_WIDTH x RESULT_WIDTH map is registered. The
//   registered result therefore appears one cycle after the input.
//
//   The max tree is purely combinational. Only the output registers are
//   clocked.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous, active-low reset (clears result and out_valid)
//   in_valid   in   input_vec carries a complete map this cycle
//   input_vec  in   [0:AW*AW-1] elements, element (r,c) at index r*AW+c
//   out_valid  out  result holds a map pooled on the previous edge
//   result     out  [0:RW*RW-1] elements, element (i,j) at index i*RW+j
//
// Handshake: in_valid qualifies input_vec for exactly the cycle it is high.
// There is no ready or backpressure; a map is accepted on every edge where
// in_valid=1. out_valid is high for one cycle per accepted map. result
// holds its last value while out_valid is low.
// -----------------------------------------------------------------------------
module max_pool_2x2 #(
  parameter int IP_DATA_WIDTH = 7,
  parameter int ARRAY_WIDTH   = 4,
  parameter int RESULT_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [IP_DATA_WIDTH:0]   input_vec [0:ARRAY_WIDTH*ARRAY_WIDTH-1],
  output logic                     out_valid,
  output logic [IP_DATA_WIDTH:0]   result    [0:RESULT_WIDTH*RESULT_WIDTH-1]
);

  localparam int NUM_RES = RESULT_WIDTH * RESULT_WIDTH;

  typedef logic [IP_DATA_WIDTH:0] elem_t;

  // Elaboration-time sanity check on the geometry.
  if ((RESULT_WIDTH != ARRAY_WIDTH / 2) || (ARRAY_WIDTH < 2)) begin : g_param_err
    $error("max_pool_2x2: RESULT_WIDTH must equal ARRAY_WIDTH/2 and ARRAY_WIDTH must be >= 2");
  end

  elem_t result_d [0:NUM_RES-1];
  elem_t result_q [0:NUM_RES-1];
  logic  out_valid_q;

  // One balanced two-level max tree per window. With an odd ARRAY_WIDTH the
  // last row and column never fall inside a window and are simply unused.
  for (genvar gi = 0; gi < RESULT_WIDTH; gi++) begin : g_row
    for (genvar gj = 0; gj < RESULT_WIDTH; gj++) begin : g_col
      elem_t p00, p01, p10, p11;
      elem_t top_max, bot_max;

      assign p00 = input_vec[(2*gi)   * ARRAY_WIDTH + 2*gj];
      assign p01 = input_vec[(2*gi)   * ARRAY_WIDTH + 2*gj + 1];
      assign p10 = input_vec[(2*gi+1) * ARRAY_WIDTH + 2*gj];
      assign p11 = input_vec[(2*gi+1) * ARRAY_WIDTH + 2*gj + 1];

      // Unsigned compares. Ties pick either operand, and both are the same value.
      assign top_max = (p00 >= p01) ? p00 : p01;
      assign bot_max = (p10 >= p11) ? p10 : p11;
      assign result_d[gi*RESULT_WIDTH + gj] = (top_max >= bot_max) ? top_max : bot_max;
    end
  end

  // The registers load only when in_valid=1. Data on input_vec while
  // in_valid=0, including X, never reaches result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      for (int k = 0; k < NUM_RES; k++) begin
        result_q[k] <= '0;
      end
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NUM_RES; k++) begin
          result_q[k] <= result_d[k];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// -----------------------------------------------------------------------------
// tb_max_pool_2x2
//   Self-checking bench for max_pool_2x2 (default geometry 4x4 -> 2x2, 8-bit).
//   Each scenario task drives stimulus and compares the DUT outputs against
//   expectations. Expectations come either from constants derived from the
//   pooling rule or from a window-max reference model.
// -----------------------------------------------------------------------------
module tb_max_pool_2x2;

  localparam int AW = 4;
  localparam int RW = 2;
  localparam int N  = AW * AW;
  localparam int NR = RW * RW;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [7:0] input_vec [0:N-1];
  logic       out_valid;
  logic [7:0] result    [0:NR-1];

  max_pool_2x2 #(
    .IP_DATA_WIDTH (7),
    .ARRAY_WIDTH   (AW),
    .RESULT_WIDTH  (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .input_vec (input_vec),
    .out_valid (out_valid),
    .result    (result)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what result/out_valid should show after each edge.
  logic [7:0] mdl_res [0:NR-1];
  logic       mdl_valid;

  // scoreboard of expected pooled maps (packed, element k at [k*8 +: 8])
  logic [NR*8-1:0] exp_q [$];

  // Window maximum computed directly from the pooling definition.
  function automatic logic [NR*8-1:0] pool_ref(input logic [7:0] m [0:N-1]);
    logic [NR*8-1:0] r;
    int best;
    r = '0;
    for (int i = 0; i < RW; i++) begin
      for (int j = 0; j < RW; j++) begin
        best = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (int'(m[(2*i+dr)*AW + 2*j+dc]) > best) best = int'(m[(2*i+dr)*AW + 2*j+dc]);
        r[(i*RW+j)*8 +: 8] = best[7:0];
      end
    end
    return r;
  endfunction

  // driver tasks
  task automatic fill_random();
    for (int k = 0; k < N; k++) input_vec[k] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int k = 0; k < N; k++) input_vec[k] = v;
  endtask

  // Apply in_valid/rst_n for one rising edge, advance the model, and return
  // 1 time unit after the edge so the outputs are sampled away from it.
  task automatic step(input logic v, input logic r);
    logic [NR*8-1:0] p;
    in_valid = v;
    rst_n    = r;
    @(posedge clk);
    if (!r) begin
      mdl_valid = 1'b0;
      for (int k = 0; k < NR; k++) mdl_res[k] = 8'd0;
    end else begin
      mdl_valid = v;
      if (v) begin
        p = pool_ref(input_vec);
        for (int k = 0; k < NR; k++) mdl_res[k] = p[k*8 +: 8];
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    fill_random();
    step(1'b1, 1'b0);
    fill_random();
    step(1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== 8'd0) begin
        n_bad++; $display("FAIL reset_res[%0d] got %0d exp 0", k, result[k]);
      end
    end
  endtask

  task automatic test_ramp();
    logic [7:0] exp_r [0:NR-1];
    exp_r[0] = 8'd5; exp_r[1] = 8'd7; exp_r[2] = 8'd13; exp_r[3] = 8'd15;
    for (int k = 0; k < N; k++) input_vec[k] = 8'(k);
    step(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL ramp_valid got %b exp 1", out_valid);
    end
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== exp_r[k]) begin
        n_bad++; $display("FAIL ramp_res[%0d] got %0d exp %0d", k, result[k], exp_r[k]);
      end
    end
    // Idle cycle with X on the inputs: result must hold and stay clean.
    for (int k = 0; k < N; k++) input_vec[k] = 8'bx;
    step(1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ramp_idle_valid got %b exp 0", out_valid);
    end
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== exp_r[k]) begin
        n_bad++; $display("FAIL ramp_hold[%0d] got %0d exp %0d", k, result[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_position();
    logic [7:0] e;
    for (int w = 0; w < NR; w++) begin
      for (int p = 0; p < 4; p++) begin
        fill_const(8'd0);
        input_vec[(2*(w/RW) + p/2)*AW + 2*(w%RW) + p%2] = 8'hFF;
        step(1'b1, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_bad++; $display("FAIL pos_valid w%0d p%0d got %b exp 1", w, p, out_valid);
        end
        for (int k = 0; k < NR; k++) begin
          e = (k == w) ? 8'd255 : 8'd0;
          n_cmp++;
          if (result[k] !== e) begin
            n_bad++; $display("FAIL pos_res w%0d p%0d [%0d] got %0d exp %0d", w, p, k, result[k], e);
          end
        end
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] exp_r [0:NR-1];
    fill_const(8'hFF);
    step(1'b1, 1'b1);
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== 8'd255) begin
        n_bad++; $display("FAIL allff_res[%0d] got %0d exp 255", k, result[k]);
      end
    end
    // window 0 = {3,3,3,3}, window 1 = {128,127,0,1}, windows 2/3 = 0
    fill_const(8'd0);
    input_vec[0] = 8'd3;   input_vec[1] = 8'd3;   input_vec[4] = 8'd3; input_vec[5] = 8'd3;
    input_vec[2] = 8'd128; input_vec[3] = 8'd127; input_vec[6] = 8'd0; input_vec[7] = 8'd1;
    exp_r[0] = 8'd3; exp_r[1] = 8'd128; exp_r[2] = 8'd0; exp_r[3] = 8'd0;
    step(1'b1, 1'b1);
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== exp_r[k]) begin
        n_bad++; $display("FAIL tie_unsigned_res[%0d] got %0d exp %0d", k, result[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NR*8-1:0] e;
    for (int m = 0; m < 3; m++) begin
      fill_random();
      exp_q.push_back(pool_ref(input_vec));
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++; $display("FAIL b2b_valid map%0d got %b exp 1", m, out_valid);
      end
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (result[k] !== e[k*8 +: 8]) begin
          n_bad++; $display("FAIL b2b_res map%0d [%0d] got %0d exp %0d", m, k, result[k], e[k*8 +: 8]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic v;
    for (int c = 0; c < 40; c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) fill_random();
      else for (int k = 0; k < N; k++) input_vec[k] = 8'bx;
      step(v, 1'b1);
      n_cmp++;
      if (out_valid !== mdl_valid) begin
        n_bad++; $display("FAIL rand_valid cyc%0d got %b exp %b", c, out_valid, mdl_valid);
      end
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (result[k] !== mdl_res[k]) begin
          n_bad++; $display("FAIL rand_res cyc%0d [%0d] got %0d exp %0d", c, k, result[k], mdl_res[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NR*8-1:0] e;
    fill_random();
    step(1'b1, 1'b1);
    // next map arrives together with reset: must be discarded
    fill_random();
    step(1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_valid got %b exp 0", out_valid);
    end
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== 8'd0) begin
        n_bad++; $display("FAIL midrst_res[%0d] got %0d exp 0", k, result[k]);
      end
    end
    step(1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_after_valid got %b exp 0", out_valid);
    end
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== 8'd0) begin
        n_bad++; $display("FAIL midrst_after_res[%0d] got %0d exp 0", k, result[k]);
      end
    end
    // first valid map after reset is emitted one cycle later as normal
    fill_random();
    e = pool_ref(input_vec);
    step(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL postrst_valid got %b exp 1", out_valid);
    end
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (result[k] !== e[k*8 +: 8]) begin
        n_bad++; $display("FAIL postrst_res[%0d] got %0d exp %0d", k, result[k], e[k*8 +: 8]);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mdl_valid = 1'b0;
    for (int k = 0; k < NR; k++) mdl_res[k] = 8'd0;
    for (int k = 0; k < N; k++) input_vec[k] = 8'd0;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_position();
    test_extremes();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
